// File: rtl/resposta_alarme_pkg.sv
// Shared definitions for the alarm response controller: state encoding,
// debug/counter widths and a timer-width helper.
package resposta_alarme_pkg;

    typedef enum logic [1:0] {
        REPOUSO  = 2'd0,
        ATRASO   = 2'd1,
        DISPARO  = 2'd2,
        SILENCIO = 2'd3
    } estado_t;

    localparam int LARG_ESTADO   = 2;
    localparam int LARG_DISPAROS = 8;
    localparam logic [LARG_DISPAROS-1:0] DISPAROS_MAX = 8'd255;

    // Bits needed to hold a down-count starting at valor-1.
    function automatic int largura(input int valor);
        return (valor < 2) ? 1 : $clog2(valor);
    endfunction

endpackage

// File: rtl/temporizador_descendente.sv
// Loadable down-counter that holds at zero and flags it; load wins over decrement.
module temporizador_descendente #(
    parameter int LARGURA = 8
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_carregar,
    input  logic [LARGURA-1:0] i_valor,
    input  logic               i_decrementar,
    output logic               o_zero
);

    logic [LARGURA-1:0] r_contagem;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_contagem <= '0;
        end else if (i_carregar) begin
            r_contagem <= i_valor;
        end else if (i_decrementar && (r_contagem != '0)) begin
            r_contagem <= r_contagem - 1'b1;
        end
    end

    assign o_zero = (r_contagem == '0);

endmodule

// File: rtl/resposta_alarme.sv
// Alarm response controller: entry delay, timed pulsed siren, alert lamp, keypad lockout.
// Optional activation counter enabled by defining RESPOSTA_CONTADOR_DISPAROS_EN.
module resposta_alarme
    import resposta_alarme_pkg::*;
#(
    parameter int ATRASO_ENTRADA = 16,
    parameter int TEMPO_SIRENE   = 256,
    parameter int MEIO_TOM       = 4,
    parameter int MAX_ERROS      = 3,
    parameter int TEMPO_BLOQUEIO = 64
) (
    input  logic                     gerador_frequencia,
    input  logic                     reset_n,
    input  logic                     alarme,
    input  logic                     senha_ok,
    input  logic                     senha_erro,
    output logic                     sirene,
    output logic                     luz_alerta,
    output logic                     bloqueado,
    output logic [LARG_ESTADO-1:0]   estado,
    output logic [LARG_DISPAROS-1:0] disparos
);

    localparam int LARG_T   = largura((ATRASO_ENTRADA > TEMPO_SIRENE) ? ATRASO_ENTRADA : TEMPO_SIRENE);
    localparam int LARG_TOM = largura(MEIO_TOM);
    localparam int LARG_BLQ = largura(TEMPO_BLOQUEIO);

    localparam logic [LARG_T-1:0]   CARGA_ATRASO  = LARG_T'(ATRASO_ENTRADA - 1);
    localparam logic [LARG_T-1:0]   CARGA_SIRENE  = LARG_T'(TEMPO_SIRENE - 1);
    localparam logic [LARG_TOM-1:0] CARGA_TOM     = LARG_TOM'(MEIO_TOM - 1);
    localparam logic [LARG_BLQ-1:0] CARGA_BLQ     = LARG_BLQ'(TEMPO_BLOQUEIO - 1);
    localparam logic [3:0]          ERROS_LIMITE  = 4'(MAX_ERROS - 1);

    estado_t    r_estado;
    logic       r_alarme_d;
    logic       r_sirene;
    logic       r_luz;
    logic       r_bloqueado;
    logic [3:0] r_erros;

    estado_t     w_prox;
    logic        w_trigger, w_ok_ef, w_erro_ef, w_bloq_inicio;
    logic        w_entra_atraso, w_entra_disparo;
    logic        w_t_zero, w_tom_zero, w_blq_zero;
    logic        w_t_carregar, w_t_dec, w_tom_carregar, w_tom_dec;
    logic [LARG_T-1:0] w_t_valor;

    // Strobes are dead during lockout; a simultaneous ok+erro counts as erro only.
    assign w_trigger     = alarme & ~r_alarme_d;
    assign w_erro_ef     = senha_erro & ~r_bloqueado;
    assign w_ok_ef       = senha_ok & ~senha_erro & ~r_bloqueado;
    assign w_bloq_inicio = w_erro_ef & (r_erros == ERROS_LIMITE);

    always_comb begin
        w_prox          = r_estado;
        w_entra_atraso  = 1'b0;
        w_entra_disparo = 1'b0;
        if (w_ok_ef) begin
            w_prox = REPOUSO;
        end else begin
            case (r_estado)
                REPOUSO: if (w_trigger) begin
                    w_prox         = ATRASO;
                    w_entra_atraso = 1'b1;
                end
                ATRASO: if (w_bloq_inicio || w_t_zero) begin
                    w_prox          = DISPARO;
                    w_entra_disparo = 1'b1;
                end
                DISPARO: if (w_t_zero) w_prox = SILENCIO;
                SILENCIO: if (w_trigger) begin
                    w_prox          = DISPARO;
                    w_entra_disparo = 1'b1;
                end
                default: w_prox = REPOUSO;
            endcase
        end
    end

    assign w_t_carregar   = w_entra_atraso | w_entra_disparo;
    assign w_t_valor      = w_entra_disparo ? CARGA_SIRENE : CARGA_ATRASO;
    assign w_t_dec        = (r_estado == ATRASO) || (r_estado == DISPARO);
    assign w_tom_carregar = w_entra_disparo | ((r_estado == DISPARO) & w_tom_zero);
    assign w_tom_dec      = (r_estado == DISPARO);

    temporizador_descendente #(.LARGURA(LARG_T)) u_tempo_estado (
        .i_clk        (gerador_frequencia),
        .i_reset_n    (reset_n),
        .i_carregar   (w_t_carregar),
        .i_valor      (w_t_valor),
        .i_decrementar(w_t_dec),
        .o_zero       (w_t_zero)
    );

    temporizador_descendente #(.LARGURA(LARG_BLQ)) u_tempo_bloqueio (
        .i_clk        (gerador_frequencia),
        .i_reset_n    (reset_n),
        .i_carregar   (w_bloq_inicio),
        .i_valor      (CARGA_BLQ),
        .i_decrementar(r_bloqueado),
        .o_zero       (w_blq_zero)
    );

    temporizador_descendente #(.LARGURA(LARG_TOM)) u_fase_tom (
        .i_clk        (gerador_frequencia),
        .i_reset_n    (reset_n),
        .i_carregar   (w_tom_carregar),
        .i_valor      (CARGA_TOM),
        .i_decrementar(w_tom_dec),
        .o_zero       (w_tom_zero)
    );

    always_ff @(posedge gerador_frequencia) begin
        if (!reset_n) begin
            r_estado    <= REPOUSO;
            r_alarme_d  <= 1'b0;
            r_sirene    <= 1'b0;
            r_luz       <= 1'b0;
            r_bloqueado <= 1'b0;
            r_erros     <= '0;
        end else begin
            r_estado   <= w_prox;
            r_alarme_d <= alarme;
            r_luz      <= (w_prox == DISPARO) || (w_prox == SILENCIO);

            if (w_entra_disparo)        r_sirene <= 1'b1;
            else if (w_prox != DISPARO) r_sirene <= 1'b0;
            else if (w_tom_zero)        r_sirene <= ~r_sirene;

            if (w_bloq_inicio)                  r_bloqueado <= 1'b1;
            else if (r_bloqueado && w_blq_zero) r_bloqueado <= 1'b0;

            if (w_ok_ef || w_bloq_inicio) r_erros <= '0;
            else if (w_erro_ef)           r_erros <= r_erros + 1'b1;
        end
    end

    assign estado     = r_estado;
    assign sirene     = r_sirene;
    assign luz_alerta = r_luz;
    assign bloqueado  = r_bloqueado;

`ifdef RESPOSTA_CONTADOR_DISPAROS_EN
    logic [LARG_DISPAROS-1:0] r_disparos;

    always_ff @(posedge gerador_frequencia) begin
        if (!reset_n) begin
            r_disparos <= '0;
        end else if (w_entra_disparo && (r_disparos != DISPAROS_MAX)) begin
            r_disparos <= r_disparos + 1'b1;
        end
    end

    assign disparos = r_disparos;
`else
    assign disparos = '0;
`endif

endmodule

// File: tb/tb_resposta_alarme.sv
// Self-checking bench for resposta_alarme: an age-based reference model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_resposta_alarme;

    localparam int ATRASO_ENTRADA = 16;
    localparam int TEMPO_SIRENE   = 256;
    localparam int MEIO_TOM       = 4;
    localparam int MAX_ERROS      = 3;
    localparam int TEMPO_BLOQUEIO = 64;

    logic       clk = 1'b0;
    logic       reset_n, alarme, senha_ok, senha_erro;
    logic       sirene, luz_alerta, bloqueado;
    logic [1:0] estado;
    logic [7:0] disparos;

    int total = 0;
    int bad   = 0;

`ifdef RESPOSTA_CONTADOR_DISPAROS_EN
    localparam int D_ON = 1;
`else
    localparam int D_ON = 0;
`endif

    always #5 clk = ~clk;

    resposta_alarme #(
        .ATRASO_ENTRADA(ATRASO_ENTRADA),
        .TEMPO_SIRENE  (TEMPO_SIRENE),
        .MEIO_TOM      (MEIO_TOM),
        .MAX_ERROS     (MAX_ERROS),
        .TEMPO_BLOQUEIO(TEMPO_BLOQUEIO)
    ) dut (
        .gerador_frequencia(clk),
        .reset_n           (reset_n),
        .alarme            (alarme),
        .senha_ok          (senha_ok),
        .senha_erro        (senha_erro),
        .sirene            (sirene),
        .luz_alerta        (luz_alerta),
        .bloqueado         (bloqueado),
        .estado            (estado),
        .disparos          (disparos)
    );

    task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        total++;
        if (atual !== esperado) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
        end
    endtask

    // Reference model: tracks how many cycles the controller has spent in each
    // phase and derives outputs from those ages.
    int m_state = 0, m_age = 0, m_err = 0, m_lock_age = 0, m_disp = 0;
    bit m_bloq = 0, m_prev = 0;

    task automatic entra_disparo();
        m_state = 2;
        m_age   = 1;
        if (D_ON == 1 && m_disp < 255) m_disp++;
    endtask

    task automatic modelo_passo();
        bit trig, ok_e, er_e, lk;
        if (!reset_n) begin
            m_state = 0; m_age = 0; m_err = 0; m_lock_age = 0;
            m_disp = 0; m_bloq = 0; m_prev = 0;
            return;
        end
        trig   = alarme && !m_prev;
        m_prev = alarme;
        er_e   = senha_erro && !m_bloq;
        ok_e   = senha_ok && !senha_erro && !m_bloq;
        lk     = er_e && (m_err + 1 == MAX_ERROS);
        case (m_state)
            0: if (!ok_e && trig) begin m_state = 1; m_age = 1; end
            1: if (ok_e) m_state = 0;
               else if (lk || m_age == ATRASO_ENTRADA) entra_disparo();
               else m_age++;
            2: if (ok_e) m_state = 0;
               else if (m_age == TEMPO_SIRENE) begin m_state = 3; m_age = 1; end
               else m_age++;
            default: if (ok_e) m_state = 0;
               else if (trig) entra_disparo();
               else m_age++;
        endcase
        if (m_bloq) begin
            if (m_lock_age == TEMPO_BLOQUEIO) m_bloq = 0;
            else m_lock_age++;
        end
        if (lk) begin m_bloq = 1; m_lock_age = 1; end
        if (ok_e || lk) m_err = 0;
        else if (er_e) m_err++;
    endtask

    initial forever begin
        @(posedge clk);
        modelo_passo();
    end

    initial forever begin
        @(negedge clk);
        verifica("m_estado", 32'(estado), 32'(m_state));
        verifica("m_sirene", 32'(sirene),
                 ((m_state == 2) && (((m_age - 1) / MEIO_TOM) % 2 == 0)) ? 32'd1 : 32'd0);
        verifica("m_luz", 32'(luz_alerta), (m_state >= 2) ? 32'd1 : 32'd0);
        verifica("m_bloqueado", 32'(bloqueado), 32'(m_bloq));
        verifica("m_disparos", 32'(disparos), 32'(m_disp));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic ciclo(); @(negedge clk); endtask
    task automatic pulso_alarme(); alarme = 1'b1; ciclo(); alarme = 1'b0; endtask
    task automatic strobe_ok();    senha_ok = 1'b1; ciclo(); senha_ok = 1'b0; endtask
    task automatic strobe_erro();  senha_erro = 1'b1; ciclo(); senha_erro = 1'b0; endtask

    initial begin
        int n;
        logic [7:0] pat;
        logic viu_sirene;
        reset_n = 1'b0; alarme = 1'b0; senha_ok = 1'b0; senha_erro = 1'b0;
        repeat (3) ciclo();
        reset_n = 1'b1;
        ciclo();
        verifica("reset_estado", 32'(estado), 32'd0);
        verifica("reset_saidas", {28'd0, sirene, luz_alerta, bloqueado, 1'b0}, 32'd0);
        verifica("reset_disparos", 32'(disparos), 32'd0);

        // Disarm during the entry delay.
        pulso_alarme();
        verifica("s2_atraso", 32'(estado), 32'd1);
        viu_sirene = 1'b0;
        repeat (5) begin viu_sirene |= sirene; ciclo(); end
        strobe_ok();
        verifica("s2_repouso", 32'(estado), 32'd0);
        verifica("s2_sem_sirene", 32'(viu_sirene), 32'd0);
        verifica("s2_disparos", 32'(disparos), 32'd0);
        repeat (3) ciclo();

        // Full delay, siren run and silence.
        pulso_alarme();
        n = 0;
        while (estado === 2'd1 && n < 100) begin n++; ciclo(); end
        verifica("s1_len_atraso", 32'(n), 32'd16);
        n = 0; pat = '0;
        while (estado === 2'd2 && n < 400) begin
            if (n < 8) pat = {pat[6:0], sirene};
            n++; ciclo();
        end
        verifica("s1_padrao_sirene", 32'(pat), 32'hF0);
        verifica("s1_len_disparo", 32'(n), 32'd256);
        verifica("s1_silencio", 32'(estado), 32'd3);
        verifica("s1_luz", 32'(luz_alerta), 32'd1);
        verifica("s1_disparos", 32'(disparos), 32'(D_ON * 1));

        // Retrigger from silence goes straight to the siren.
        repeat (2) ciclo();
        pulso_alarme();
        verifica("s4_disparo", 32'(estado), 32'd2);
        verifica("s4_disparos", 32'(disparos), 32'(D_ON * 2));
        repeat (2) ciclo();
        strobe_ok();
        verifica("s4_repouso", 32'(estado), 32'd0);
        verifica("s4_luz", 32'(luz_alerta), 32'd0);
        repeat (2) ciclo();

        // Three wrong codes in the delay force the siren and lock the keypad.
        pulso_alarme();
        repeat (2) ciclo();
        strobe_erro(); ciclo();
        strobe_erro(); ciclo();
        strobe_erro();
        verifica("s3_disparo", 32'(estado), 32'd2);
        verifica("s3_bloqueado", 32'(bloqueado), 32'd1);
        n = 0;
        while (bloqueado === 1'b1 && n < 200) begin
            senha_ok = (n == 5);
            n++; ciclo();
        end
        senha_ok = 1'b0;
        verifica("s3_len_bloqueio", 32'(n), 32'd64);
        verifica("s3_ok_ignorado", 32'(estado), 32'd2);
        verifica("s3_disparos", 32'(disparos), 32'(D_ON * 3));

        // Simultaneous ok+erro counts as one error.
        senha_ok = 1'b1; senha_erro = 1'b1; ciclo();
        senha_ok = 1'b0; senha_erro = 1'b0;
        verifica("s5_fica_disparo", 32'(estado), 32'd2);
        strobe_erro();
        verifica("s5_erro2_livre", 32'(bloqueado), 32'd0);
        strobe_erro();
        verifica("s5_erro3_bloqueia", 32'(bloqueado), 32'd1);
        ciclo();

        // One-cycle reset in the middle of the siren.
        reset_n = 1'b0; ciclo(); reset_n = 1'b1;
        verifica("rst_estado", 32'(estado), 32'd0);
        verifica("rst_saidas", {28'd0, sirene, luz_alerta, bloqueado, 1'b0}, 32'd0);
        verifica("rst_disparos", 32'(disparos), 32'd0);
        repeat (3) ciclo();
        verifica("rst_repouso", 32'(estado), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
